// File: rtl/tage_pkg.sv
// ----------------------------------------------------------------------------
// tage_pkg
//   Shared definitions for the TAGE tagged component.
//   - FSM state encoding (INIT / RUN / AGE) as plain logic constants
//   - Next-entry operation codes used by tage_sat_update
//   - Weak-taken / weak-not-taken counter values as functions of the
//     counter width
//   - Entry layout {tag, ctr, u} for the default geometry (TL=8, CL=3, UL=2)
// ----------------------------------------------------------------------------
package tage_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_INIT = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_AGE  = 2'd2;

    // Operation applied to one entry by the shared next-entry calculator.
    typedef logic [1:0] entry_op_t;

    localparam entry_op_t OP_TRAIN = 2'd0;
    localparam entry_op_t OP_ALLOC = 2'd1;
    localparam entry_op_t OP_AGE   = 2'd2;
    localparam entry_op_t OP_CLEAR = 2'd3;

    // Weak taken: MSB set, all lower bits clear (e.g. 4 for a 3-bit counter).
    function automatic int CTR_WEAK_T(input int cl);
        return 1 << (cl - 1);
    endfunction

    // Weak not-taken: MSB clear, all lower bits set (e.g. 3 for a 3-bit counter).
    function automatic int CTR_WEAK_NT(input int cl);
        return (1 << (cl - 1)) - 1;
    endfunction

    // Entry view for the default geometry; the table itself stores entries
    // as flat {tag, ctr, u} vectors so that it can be resized by parameter.
    typedef struct packed {
        logic [7:0] tag;
        logic [2:0] ctr;
        logic [1:0] u;
    } entry_t;

endpackage

// File: rtl/tage_sat_update.sv
// ----------------------------------------------------------------------------
// tage_sat_update
//   Combinational next-entry calculator. Given the current contents of one
//   table entry and an operation, produces the contents to write back.
//   The same result feeds the storage write port and the lookup bypass, so a
//   lookup that collides with the entry being written sees exactly what gets
//   stored.
//
//   Ports
//     op        in   2   OP_TRAIN / OP_ALLOC / OP_AGE / OP_CLEAR
//     cur_tag   in   TL  current stored tag
//     cur_ctr   in   CL  current direction counter
//     cur_u     in   UL  current useful counter
//     new_tag   in   TL  tag written on allocate
//     taken     in   1   resolved direction (train / allocate)
//     u_inc     in   1   useful +1 request (train only)
//     u_dec     in   1   useful -1 request (train only)
//     nxt_tag   out  TL  tag to store
//     nxt_ctr   out  CL  counter to store
//     nxt_u     out  UL  useful counter to store
// ----------------------------------------------------------------------------
module tage_sat_update
    import tage_pkg::*;
#(
    parameter int TL = 8,
    parameter int CL = 3,
    parameter int UL = 2
) (
    input  logic [1:0]    op,
    input  logic [TL-1:0] cur_tag,
    input  logic [CL-1:0] cur_ctr,
    input  logic [UL-1:0] cur_u,
    input  logic [TL-1:0] new_tag,
    input  logic          taken,
    input  logic          u_inc,
    input  logic          u_dec,
    output logic [TL-1:0] nxt_tag,
    output logic [CL-1:0] nxt_ctr,
    output logic [UL-1:0] nxt_u
);

    localparam logic [CL-1:0] CTR_MAX  = '1;
    localparam logic [CL-1:0] CTR_ONE  = CL'(1);
    localparam logic [CL-1:0] WEAK_T   = CL'(CTR_WEAK_T(CL));
    localparam logic [CL-1:0] WEAK_NT  = CL'(CTR_WEAK_NT(CL));
    localparam logic [UL-1:0] U_MAX    = '1;
    localparam logic [UL-1:0] U_ONE    = UL'(1);

    // Saturating counter arithmetic. Simultaneous inc and dec on the useful
    // counter cancel out rather than picking a winner.
    always_comb begin
        nxt_tag = cur_tag;
        nxt_ctr = cur_ctr;
        nxt_u   = cur_u;
        case (op)
            OP_TRAIN: begin
                if (taken) begin
                    if (cur_ctr != CTR_MAX) begin
                        nxt_ctr = cur_ctr + CTR_ONE;
                    end
                end else begin
                    if (cur_ctr != '0) begin
                        nxt_ctr = cur_ctr - CTR_ONE;
                    end
                end
                if (u_inc && !u_dec) begin
                    if (cur_u != U_MAX) begin
                        nxt_u = cur_u + U_ONE;
                    end
                end else if (u_dec && !u_inc) begin
                    if (cur_u != '0) begin
                        nxt_u = cur_u - U_ONE;
                    end
                end
            end
            OP_ALLOC: begin
                nxt_tag = new_tag;
                nxt_ctr = taken ? WEAK_T : WEAK_NT;
                nxt_u   = '0;
            end
            OP_AGE: begin
                nxt_u = cur_u >> 1;
            end
            default: begin
                nxt_tag = '0;
                nxt_ctr = WEAK_NT;
                nxt_u   = '0;
            end
        endcase
    end

endmodule

// File: rtl/tagged_counter_table.sv
// ----------------------------------------------------------------------------
// tagged_counter_table
//   TAGE tagged component: 2**IL entries of {tag, direction counter, useful
//   counter}. One registered lookup port and one update/allocate port.
//   After reset the table clears itself one entry per cycle (INIT); on
//   request the useful counters are halved one entry per cycle (AGE).
//
//   Ports
//     Clk            in   1   clock, all logic on posedge
//     reset          in   1   synchronous, active-high
//     rd_valid       in   1   lookup request
//     rd_index       in   IL  lookup index
//     rd_tag         in   TL  lookup tag
//     rd_resp_valid  out  1   lookup result valid (one cycle after accept)
//     rd_hit         out  1   stored tag matched rd_tag
//     rd_ctr         out  CL  stored direction counter
//     rd_u           out  UL  stored useful counter
//     upd_valid      in   1   update request, taken only when upd_ready=1
//     upd_ready      out  1   high only in RUN
//     upd_index      in   IL  entry to modify
//     upd_alloc      in   1   1: allocate, 0: train
//     upd_tag        in   TL  tag written on allocate
//     upd_taken      in   1   resolved direction
//     upd_u_inc      in   1   useful +1 (train only)
//     upd_u_dec      in   1   useful -1 (train only)
//     age_req        in   1   pulse to start an aging sweep (RUN only)
//     busy           out  1   high during INIT or AGE
// ----------------------------------------------------------------------------
module tagged_counter_table
    import tage_pkg::*;
#(
    parameter int IL = 10,
    parameter int TL = 8,
    parameter int CL = 3,
    parameter int UL = 2
) (
    input  logic          Clk,
    input  logic          reset,
    input  logic          rd_valid,
    input  logic [IL-1:0] rd_index,
    input  logic [TL-1:0] rd_tag,
    output logic          rd_resp_valid,
    output logic          rd_hit,
    output logic [CL-1:0] rd_ctr,
    output logic [UL-1:0] rd_u,
    input  logic          upd_valid,
    output logic          upd_ready,
    input  logic [IL-1:0] upd_index,
    input  logic          upd_alloc,
    input  logic [TL-1:0] upd_tag,
    input  logic          upd_taken,
    input  logic          upd_u_inc,
    input  logic          upd_u_dec,
    input  logic          age_req,
    output logic          busy
);

    localparam int N  = 1 << IL;
    localparam int EW = TL + CL + UL;

    // Entry layout inside one storage word: {tag, ctr, u}.
    logic [EW-1:0] mem [N];

    state_t        state;
    logic [IL-1:0] sweep_ptr;
    logic          sweep_last;

    logic          wr_en;
    logic [IL-1:0] wr_index;
    entry_op_t     wr_op;
    logic [EW-1:0] wr_cur;
    logic [EW-1:0] wr_data;
    logic [TL-1:0] nxt_tag;
    logic [CL-1:0] nxt_ctr;
    logic [UL-1:0] nxt_u;

    logic          rd_accept;
    logic [EW-1:0] rd_entry;

    assign sweep_last = (sweep_ptr == '1);
    assign upd_ready  = (state == ST_RUN);
    assign busy       = (state == ST_INIT) || (state == ST_AGE);

    // Controller. INIT and AGE both walk sweep_ptr from 0 to the last entry
    // and then fall back to RUN; the pointer wraps to 0 on its own at the end
    // of a sweep. age_req is only looked at in RUN, so a request arriving
    // during a sweep is simply lost.
    always_ff @(posedge Clk) begin
        if (reset) begin
            state     <= ST_INIT;
            sweep_ptr <= '0;
        end else begin
            case (state)
                ST_INIT, ST_AGE: begin
                    sweep_ptr <= sweep_ptr + IL'(1);
                    if (sweep_last) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (age_req) begin
                        state     <= ST_AGE;
                        sweep_ptr <= '0;
                    end
                end
                default: begin
                    state     <= ST_INIT;
                    sweep_ptr <= '0;
                end
            endcase
        end
    end

    // Select the single write for this cycle. Sweeps own the write port for
    // their whole duration, which is why updates are refused outside RUN.
    always_comb begin
        wr_en    = 1'b0;
        wr_index = sweep_ptr;
        wr_op    = OP_CLEAR;
        case (state)
            ST_INIT: begin
                wr_en = 1'b1;
                wr_op = OP_CLEAR;
            end
            ST_AGE: begin
                wr_en = 1'b1;
                wr_op = OP_AGE;
            end
            ST_RUN: begin
                if (upd_valid) begin
                    wr_en    = 1'b1;
                    wr_index = upd_index;
                    wr_op    = upd_alloc ? OP_ALLOC : OP_TRAIN;
                end
            end
            default: begin
                wr_en = 1'b0;
            end
        endcase
        if (reset) begin
            wr_en = 1'b0;
        end
    end

    assign wr_cur = mem[wr_index];

    tage_sat_update #(
        .TL (TL),
        .CL (CL),
        .UL (UL)
    ) u_sat_update (
        .op      (wr_op),
        .cur_tag (wr_cur[EW-1 -: TL]),
        .cur_ctr (wr_cur[UL +: CL]),
        .cur_u   (wr_cur[UL-1:0]),
        .new_tag (upd_tag),
        .taken   (upd_taken),
        .u_inc   (upd_u_inc),
        .u_dec   (upd_u_dec),
        .nxt_tag (nxt_tag),
        .nxt_ctr (nxt_ctr),
        .nxt_u   (nxt_u)
    );

    assign wr_data = {nxt_tag, nxt_ctr, nxt_u};

    // Storage has no reset: the INIT sweep is what gives it defined contents.
    always_ff @(posedge Clk) begin
        if (wr_en) begin
            mem[wr_index] <= wr_data;
        end
    end

    // A lookup colliding with this cycle's write returns the value being
    // written, covering both same-index updates and the entry being aged.
    assign rd_accept = rd_valid && (state != ST_INIT);
    assign rd_entry  = (wr_en && (wr_index == rd_index)) ? wr_data : mem[rd_index];

    // Registered lookup result; data outputs are forced to zero whenever no
    // response is being presented.
    always_ff @(posedge Clk) begin
        if (reset) begin
            rd_resp_valid <= 1'b0;
            rd_hit        <= 1'b0;
            rd_ctr        <= '0;
            rd_u          <= '0;
        end else begin
            rd_resp_valid <= rd_accept;
            if (rd_accept) begin
                rd_hit <= (rd_entry[EW-1 -: TL] == rd_tag);
                rd_ctr <= rd_entry[UL +: CL];
                rd_u   <= rd_entry[UL-1:0];
            end else begin
                rd_hit <= 1'b0;
                rd_ctr <= '0;
                rd_u   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_tagged_counter_table.sv
// ----------------------------------------------------------------------------
// tb_tagged_counter_table
//   Scoreboard bench for tagged_counter_table with IL=4, TL=8, CL=3, UL=2.
//   The stimulus side keeps a plain array model of the table and pushes the
//   expected lookup result into a queue; a monitor pops and compares whenever
//   the DUT presents a response.
// ----------------------------------------------------------------------------
module tb_tagged_counter_table;

    localparam int IL = 4;
    localparam int TL = 8;
    localparam int CL = 3;
    localparam int UL = 2;
    localparam int N  = 1 << IL;

    localparam int CTR_MAX = (1 << CL) - 1;
    localparam int WEAK_T  = 1 << (CL - 1);
    localparam int WEAK_NT = WEAK_T - 1;
    localparam int U_MAX   = (1 << UL) - 1;

    logic          Clk = 1'b0;
    logic          reset = 1'b1;
    logic          rd_valid;
    logic [IL-1:0] rd_index;
    logic [TL-1:0] rd_tag;
    logic          rd_resp_valid;
    logic          rd_hit;
    logic [CL-1:0] rd_ctr;
    logic [UL-1:0] rd_u;
    logic          upd_valid;
    logic          upd_ready;
    logic [IL-1:0] upd_index;
    logic          upd_alloc;
    logic [TL-1:0] upd_tag;
    logic          upd_taken;
    logic          upd_u_inc;
    logic          upd_u_dec;
    logic          age_req;
    logic          busy;

    always #5 Clk = ~Clk;

    tagged_counter_table #(
        .IL (IL),
        .TL (TL),
        .CL (CL),
        .UL (UL)
    ) dut (
        .Clk           (Clk),
        .reset         (reset),
        .rd_valid      (rd_valid),
        .rd_index      (rd_index),
        .rd_tag        (rd_tag),
        .rd_resp_valid (rd_resp_valid),
        .rd_hit        (rd_hit),
        .rd_ctr        (rd_ctr),
        .rd_u          (rd_u),
        .upd_valid     (upd_valid),
        .upd_ready     (upd_ready),
        .upd_index     (upd_index),
        .upd_alloc     (upd_alloc),
        .upd_tag       (upd_tag),
        .upd_taken     (upd_taken),
        .upd_u_inc     (upd_u_inc),
        .upd_u_dec     (upd_u_dec),
        .age_req       (age_req),
        .busy          (busy)
    );

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        bit hit;
        int ctr;
        int u;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int m_tag [N];
    int m_ctr [N];
    int m_u   [N];

    bit mon_en = 1'b0;

    // One comparison: counts it, and reports it when it does not match.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < N; i++) begin
            m_tag[i] = 0;
            m_ctr[i] = WEAK_NT;
            m_u[i]   = 0;
        end
    endfunction

    function automatic void model_update(input int idx, input bit alloc, input int tag,
                                         input bit taken, input bit inc, input bit dec);
        if (alloc) begin
            m_tag[idx] = tag;
            m_ctr[idx] = taken ? WEAK_T : WEAK_NT;
            m_u[idx]   = 0;
        end else begin
            if (taken) m_ctr[idx] = (m_ctr[idx] < CTR_MAX) ? m_ctr[idx] + 1 : CTR_MAX;
            else       m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
            if (inc && !dec)      m_u[idx] = (m_u[idx] < U_MAX) ? m_u[idx] + 1 : U_MAX;
            else if (dec && !inc) m_u[idx] = (m_u[idx] > 0) ? m_u[idx] - 1 : 0;
        end
    endfunction

    // Drives one RUN-state cycle. The model applies the update before the
    // lookup so a same-index lookup expects the post-update entry.
    task automatic applyStimulus(input bit do_rd, input int ri, input int rt,
                                 input bit do_upd, input int ui, input bit alloc,
                                 input int ut, input bit taken, input bit inc, input bit dec);
        exp_t e;
        rd_valid  = do_rd;
        rd_index  = ri[IL-1:0];
        rd_tag    = rt[TL-1:0];
        upd_valid = do_upd;
        upd_index = ui[IL-1:0];
        upd_alloc = alloc;
        upd_tag   = ut[TL-1:0];
        upd_taken = taken;
        upd_u_inc = inc;
        upd_u_dec = dec;
        if (do_upd) model_update(ui, alloc, ut, taken, inc, dec);
        if (do_rd) begin
            e.hit = (m_tag[ri] == rt);
            e.ctr = m_ctr[ri];
            e.u   = m_u[ri];
            exp_q.push_back(e);
        end
        @(negedge Clk);
        rd_valid  = 1'b0;
        upd_valid = 1'b0;
        upd_alloc = 1'b0;
        upd_taken = 1'b0;
        upd_u_inc = 1'b0;
        upd_u_dec = 1'b0;
    endtask

    task automatic lookup(input int ri, input int rt);
        applyStimulus(1'b1, ri, rt, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic train(input int ui, input bit taken, input bit inc, input bit dec);
        applyStimulus(1'b0, 0, 0, 1'b1, ui, 1'b0, 0, taken, inc, dec);
    endtask

    // Counts consecutive busy cycles (starting at the current negedge) while
    // optionally poking lookups, age requests or updates that must be ignored.
    task automatic measure_busy(input bit poke_rd, input bit poke_age, input bit poke_upd,
                                output int n);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            checkOutput("upd_ready_while_busy", upd_ready, 0);
            rd_valid = poke_rd;
            rd_index = IL'($urandom_range(0, N - 1));
            rd_tag   = '0;
            age_req  = poke_age && (n == 3);
            if (poke_upd) begin
                upd_valid = 1'b1;
                upd_index = IL'($urandom_range(0, N - 1));
                upd_alloc = 1'($urandom_range(0, 1));
                upd_tag   = TL'($urandom_range(0, 255));
                upd_taken = 1'($urandom_range(0, 1));
                upd_u_dec = 1'b1;
            end
            @(negedge Clk);
        end
        rd_valid  = 1'b0;
        age_req   = 1'b0;
        upd_valid = 1'b0;
        upd_alloc = 1'b0;
        upd_u_dec = 1'b0;
    endtask

    // Monitor: every presented response is matched against the oldest
    // outstanding expectation; idle cycles must show zeroed data.
    always @(negedge Clk) begin
        if (mon_en) begin
            if (rd_resp_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_resp: actual=response required=none (idx hit=%0d ctr=%0d u=%0d)",
                             rd_hit, rd_ctr, rd_u);
                end else begin
                    mon_e = exp_q.pop_front();
                    checkOutput("rd_hit", rd_hit, mon_e.hit);
                    checkOutput("rd_ctr", rd_ctr, mon_e.ctr);
                    checkOutput("rd_u",   rd_u,   mon_e.u);
                end
            end else begin
                checkOutput("idle_data_zero", {rd_hit, rd_ctr, rd_u}, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    int n;
    int ri, ui, rt;

    initial begin
        rd_valid  = 1'b0;
        rd_index  = '0;
        rd_tag    = '0;
        upd_valid = 1'b0;
        upd_index = '0;
        upd_alloc = 1'b0;
        upd_tag   = '0;
        upd_taken = 1'b0;
        upd_u_inc = 1'b0;
        upd_u_dec = 1'b0;
        age_req   = 1'b0;
        reset     = 1'b1;

        repeat (3) @(negedge Clk);
        checkOutput("reset_resp_valid", rd_resp_valid, 0);
        checkOutput("reset_rd_hit",     rd_hit, 0);
        checkOutput("reset_rd_ctr",     rd_ctr, 0);
        checkOutput("reset_rd_u",       rd_u, 0);
        checkOutput("reset_busy",       busy, 1);
        checkOutput("reset_upd_ready",  upd_ready, 0);
        mon_en = 1'b1;

        // Release reset: lookups and an age request during INIT are ignored.
        reset = 1'b0;
        measure_busy(1'b1, 1'b1, 1'b0, n);
        checkOutput("init_busy_cycles", n, 16);
        model_clear();
        @(negedge Clk);
        checkOutput("age_req_in_init_dropped", busy, 0);
        checkOutput("upd_ready_in_run", upd_ready, 1);

        $display("[TB] directed lookups and training");
        lookup(5, 0);
        applyStimulus(1'b0, 0, 0, 1'b1, 2, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
        lookup(2, 8'hA5);
        lookup(2, 8'hA4);
        repeat (5) begin
            train(2, 1'b1, 1'b0, 1'b0);
            lookup(2, 8'hA5);
        end
        repeat (9) begin
            train(2, 1'b0, 1'b0, 1'b0);
            lookup(2, 8'hA5);
        end
        repeat (4) begin
            train(2, 1'b1, 1'b1, 1'b0);
            lookup(2, 8'hA5);
        end
        train(2, 1'b0, 1'b1, 1'b1);
        lookup(2, 8'hA5);
        // Counter now 3 (0 + 4 taken - 1 not-taken); same-cycle lookup sees 4.
        applyStimulus(1'b1, 2, 8'hA5, 1'b1, 2, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        lookup(2, 8'hA5);

        $display("[TB] randomized traffic");
        for (int k = 0; k < 300; k++) begin
            ri = $urandom_range(0, N - 1);
            ui = ($urandom_range(0, 2) == 0) ? ri : $urandom_range(0, N - 1);
            rt = ($urandom_range(0, 1) == 1) ? m_tag[ri] : $urandom_range(0, 255);
            applyStimulus($urandom_range(0, 9) < 7, ri, rt,
                          $urandom_range(0, 9) < 6, ui, $urandom_range(0, 3) == 0,
                          $urandom_range(0, 255), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] aging sweep");
        for (int i = 0; i < N; i++) begin
            repeat (3) train(i, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
        end
        age_req = 1'b1;
        @(negedge Clk);
        age_req = 1'b0;
        measure_busy(1'b0, 1'b0, 1'b1, n);
        checkOutput("age_busy_cycles", n, 16);
        for (int i = 0; i < N; i++) m_u[i] = m_u[i] / 2;
        for (int i = 0; i < N; i++) lookup(i, m_tag[i]);
        lookup(7, (m_tag[7] + 1) % 256);

        $display("[TB] reset during aging");
        age_req = 1'b1;
        @(negedge Clk);
        age_req = 1'b0;
        repeat (5) @(negedge Clk);
        reset = 1'b1;
        @(negedge Clk);
        reset = 1'b0;
        measure_busy(1'b1, 1'b1, 1'b0, n);
        checkOutput("reinit_busy_cycles", n, 16);
        model_clear();
        @(negedge Clk);
        checkOutput("age_req_in_reinit_dropped", busy, 0);
        for (int i = 0; i < N; i++) lookup(i, 0);

        repeat (3) @(negedge Clk);
        checkOutput("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
